multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a shared-memory, single-ALU multicycle RV32I datapath: fetch, decode, execute, memory and writeback over multiple cycles.
- Replaces single-cycle control decode for the multicycle core.
- Drives the ALU-operand muxes, the result mux, the register/IR/PC/memory write enables and the ALU decoder's ALUOp.
- Waits on a memory ready handshake for fetch, load and store.

Parameters:
- STATE_W, 4, width of the state register (11 states used).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode field of the IR (instr[6:0])
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = result
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Single clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset: state <= FETCH asynchronously.
  - While rst_n = 0, PCWrite, IRWrite, MemWrite, RegWrite, instr_done and illegal_op are forced to 0.
  - All mux selects take their FETCH values.
- Outputs are combinational from the state only, except for these Mealy terms: Zero in PCWrite; mem_ready in IRWrite, PCWrite, MemWrite and instr_done.
- Any signal not listed for a state is 0.
- ImmSrc is a pure function of op: 0000011/0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; otherwise 00.
- Internal PCUpdate; PCWrite = (PCUpdate & mem_ready in FETCH) | (Branch & Zero in BEQ) | PCUpdate in JAL.
- States, outputs and transitions:
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready, PCWrite=mem_ready. Next state is DECODE if mem_ready, else FETCH (IR and PC held).
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00.
    - 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
    - Any other opcode -> illegal_op=1, instr_done=1, next state FETCH; no architectural write.
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op = 0000011, else MEMWRITE.
  - MEMREAD(3): AdrSrc=1, ResultSrc=00. Next state is MEMWB if mem_ready, else MEMREAD.
  - MEMWB(4): ResultSrc=01, RegWrite=1, instr_done=1. Next state FETCH.
  - MEMWRITE(5): AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. instr_done=mem_ready. Next state is FETCH if mem_ready.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1, instr_done=1. Next state FETCH.
  - BEQ(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, PCWrite=Zero, instr_done=1. Next state FETCH.
  - JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next state ALUWB.
- Unused state encodings return to FETCH next cycle with all enables 0.
- Latencies with mem_ready tied high: R/I/BEQ = 3 or 4 cycles as shown (R/I 4, BEQ 3), lw 5, sw 4, jal 4.
- Reset asserted mid-instruction: state returns to FETCH immediately and no enable pulses fire; a store in flight is abandoned (MemWrite drops at once).

Optional Feature:
- Macro MC_JAL_EN.
- Defined: JAL state and the op = 1101111 decode exist as specified above.
- Undefined: JAL state is absent; op = 1101111 is treated as illegal (illegal_op pulse, return to FETCH). ImmSrc for 1101111 still returns 11.

Test Plan:
- Reset: rst_n low mid-MEMWRITE with mem_ready=0 -> state FETCH, MemWrite=0, RegWrite=0 within the same cycle; after release, IRWrite=1 on the first mem_ready.
- lw with mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; instr_done pulses once.
- Fetch stall: mem_ready=0 for 3 cycles then 1 -> IRWrite/PCWrite low for 3 cycles, high for exactly 1; DECODE follows.
- beq, Zero=1 then Zero=0 -> PCWrite=1 in BEQ with ALUOp=01 for Zero=1, PCWrite=0 for Zero=0; both return to FETCH after 3 cycles.
- op = 0110111 (unsupported) -> illegal_op=1 in DECODE, no RegWrite/MemWrite, FETCH next.
- jal with MC_JAL_EN defined -> JAL (PCWrite=1, ALUSrcA=01, ALUSrcB=10) then ALUWB (RegWrite=1); undefined -> illegal_op=1.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Control bundle between the multicycle RV32I controller and its datapath.
// The controller side uses the 'master' modport; the datapath (or a
// testbench standing in for it) uses the 'slave' modport.
//
// Datapath -> controller:
//   op         [6:0]  opcode field of the IR (instr[6:0])
//   Zero              ALU zero flag
//   mem_ready         memory completed the current read/write this cycle
// Controller -> datapath:
//   PCWrite           PC register enable
//   AdrSrc            memory address select (0 = PC, 1 = result)
//   MemWrite          memory write request
//   IRWrite           IR and OldPC enable
//   ResultSrc  [1:0]  00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA    [1:0]  00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB    [1:0]  00 = rs2, 01 = ImmExt, 10 = constant 4
//   ALUOp      [1:0]  00 = add, 01 = sub/compare, 10 = funct-decoded
//   ImmSrc     [1:0]  00 = I, 01 = S, 10 = B, 11 = J
//   RegWrite          register file write enable
//   instr_done        pulse on the last cycle of each instruction
//   illegal_op        pulse in DECODE for an unsupported opcode
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [6:0] op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  op, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUOp, ImmSrc, RegWrite, instr_done, illegal_op
    );

    modport slave (
        output op, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUOp, ImmSrc, RegWrite, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a shared-memory, single-ALU multicycle RV32I
// datapath. It sequences fetch, decode, execute, memory and writeback, and
// waits on mem_ready for instruction fetch, load and store.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (state -> FETCH, enables forced 0)
//   bus    multicycle_controller_if.master (opcode/flags in, controls out)
//
// Parameters:
//   STATE_W  width of the state register (11 encodings used)
//
// Build option:
//   MC_JAL_EN  when defined, the JAL state and the 1101111 decode exist;
//              otherwise 1101111 decodes as illegal (ImmSrc still 11).
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECR    = STATE_W'(6),
        S_EXECI    = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BEQ      = STATE_W'(9),
        S_JAL      = STATE_W'(10)
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e state_q, state_d;

    logic       pc_update;
    logic       branch;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                // PC + 4 is computed through ALUResult while the IR loads.
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                ir_write   = bus.mem_ready;
                pc_write   = pc_update & bus.mem_ready;
                state_d    = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // OldPC + ImmExt precomputes the branch/jump target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                unique case (bus.op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BEQ;
`ifdef MC_JAL_EN
                    OP_JAL:    state_d = S_JAL;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                // The request stays up until memory accepts it.
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = bus.mem_ready;
                state_d    = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut still holds the target computed in DECODE.
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                pc_write   = branch & bus.Zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                // PC <- target from ALUOut; ALU forms OldPC + 4 as the link.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                pc_write  = pc_update;
                state_d   = S_ALUWB;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset leaves the state in FETCH, so only the enables need masking.
        if (!rst_n) begin
            pc_write   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // Immediate format depends only on the opcode, independent of state.
    always_comb begin
        imm_src = 2'b00;
        unique case (bus.op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUOp      = alu_op;
    assign bus.ImmSrc     = imm_src;
    assign bus.RegWrite   = reg_write;
    assign bus.instr_done = instr_done;
    assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. The reference model
// describes each instruction as a string of phase letters
// (F fetch, D decode, A address, R read, L load writeback, S store,
// E exec-R, I exec-I, W ALU writeback, B branch, J jump) and derives the
// expected control word from the current letter and the live inputs.
// Honours MC_JAL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multicycle_controller_if bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Phase sequence an instruction walks through when memory never stalls.
    function automatic string phases_for(input logic [6:0] o);
        case (o)
            7'b0000011: return "FDARL";
            7'b0100011: return "FDAS";
            7'b0110011: return "FDEW";
            7'b0010011: return "FDIW";
            7'b1100011: return "FDB";
`ifdef MC_JAL_EN
            7'b1101111: return "FDJW";
`endif
            default:    return "FD";
        endcase
    endfunction

    // Expected control word:
    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,
    //  RegWrite,instr_done,illegal_op}
    function automatic logic [16:0] exp_out(input byte ph, input logic mr, input logic z,
                                            input logic [6:0] o, input logic in_rst);
        logic       pcw, adr, mw, irw, rw, done, ill;
        logic [1:0] res, sa, sb, aop, imm;
        string      seq;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
        res = 0; sa = 0; sb = 0; aop = 0;
        seq = phases_for(o);
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        case (ph)
            "F": begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            "D": begin
                sa = 2'b01; sb = 2'b01;
                if (seq.len() == 2) begin ill = 1; done = 1; end
            end
            "A": begin sa = 2'b10; sb = 2'b01; end
            "R": adr = 1;
            "L": begin res = 2'b01; rw = 1; done = 1; end
            "S": begin adr = 1; mw = 1; done = mr; end
            "E": begin sa = 2'b10; aop = 2'b10; end
            "I": begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            "W": begin rw = 1; done = 1; end
            "B": begin sa = 2'b10; aop = 2'b01; pcw = z; done = 1; end
            "J": begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (in_rst) begin
            pcw = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
        end
        return {pcw, adr, mw, irw, res, sa, sb, aop, imm, rw, done, ill};
    endfunction

    function automatic logic [16:0] dut_word();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.RegWrite,
                bus.instr_done, bus.illegal_op};
    endfunction

    // One cycle: drive at the falling edge, compare shortly after.
    task automatic step(input byte ph, input logic [6:0] o, input logic mr,
                        input logic z, input logic rst_v);
        @(negedge clk);
        bus.op        = o;
        bus.mem_ready = mr;
        bus.Zero      = z;
        rst_n         = rst_v;
        #1;
        check($sformatf("ctl[%s] op=%07b mr=%0b z=%0b rst_n=%0b", string'(ph), o, mr, z, rst_v),
              dut_word(), exp_out(ph, mr, z, o, !rst_v));
    endtask

    // mr_mode: 0 = always ready, 1 = random, 2 = not ready for first stall_n cycles
    // z_mode : 0/1 fixed Zero, 2 = random
    task automatic run_instr(input logic [6:0] o, input int mr_mode, input int stall_n,
                             input int z_mode, input int exp_lat);
        string seq;
        int    idx, cyc, dones, lat;
        logic  mr, z;
        seq = phases_for(o);
        idx = 0; cyc = 0; dones = 0; lat = -1;
        while (idx < seq.len()) begin
            if (cyc >= 200) begin
                check_int("cycle_budget", cyc, 199);
                break;
            end
            case (mr_mode)
                0:       mr = 1'b1;
                1:       mr = 1'($urandom_range(0, 1));
                default: mr = (cyc >= stall_n);
            endcase
            z = (z_mode == 2) ? 1'($urandom_range(0, 1)) : (z_mode == 1);
            step(seq[idx], o, mr, z, 1'b1);
            cyc++;
            if (bus.instr_done) begin
                dones++;
                lat = cyc;
            end
            if (!((seq[idx] == "F" || seq[idx] == "R" || seq[idx] == "S") && !mr))
                idx++;
        end
        check_int($sformatf("done_pulses op=%07b", o), dones, 1);
        if (exp_lat > 0) check_int($sformatf("latency op=%07b", o), lat, exp_lat);
    endtask

    initial begin
        logic [6:0] rop;
        total = 0;
        bad   = 0;
        bus.op = 7'b0010011;
        bus.mem_ready = 1'b0;
        bus.Zero = 1'b0;
        rst_n = 1'b0;

        // Reset: enables masked even though FETCH sees mem_ready.
        step("F", 7'b0010011, 1'b1, 1'b0, 1'b0);
        check_int("irwrite_in_reset", int'(bus.IRWrite), 0);
        step("F", 7'b0010011, 1'b1, 1'b0, 1'b0);
        step("F", 7'b0010011, 1'b0, 1'b0, 1'b1);

        // Directed instructions, memory always ready.
        run_instr(7'b0000011, 0, 0, 0, 5);  // lw
        run_instr(7'b0100011, 0, 0, 0, 4);  // sw
        run_instr(7'b0110011, 0, 0, 0, 4);  // R-type
        run_instr(7'b0010011, 0, 0, 0, 4);  // I-type
        run_instr(7'b1100011, 0, 0, 1, 3);  // beq taken
        run_instr(7'b1100011, 0, 0, 0, 3);  // beq not taken
        run_instr(7'b0110111, 0, 0, 0, 2);  // unsupported (lui)
`ifdef MC_JAL_EN
        run_instr(7'b1101111, 0, 0, 0, 4);
`else
        run_instr(7'b1101111, 0, 0, 0, 2);
`endif

        // Fetch stall of three cycles.
        run_instr(7'b0110011, 2, 3, 0, 7);

        // Reset in the middle of a stalled store.
        step("F", 7'b0100011, 1'b1, 1'b0, 1'b1);
        step("D", 7'b0100011, 1'b1, 1'b0, 1'b1);
        step("A", 7'b0100011, 1'b1, 1'b0, 1'b1);
        step("S", 7'b0100011, 1'b0, 1'b0, 1'b1);
        check_int("memwrite_before_rst", int'(bus.MemWrite), 1);
        step("F", 7'b0100011, 1'b0, 1'b0, 1'b0);
        check_int("memwrite_in_rst", int'(bus.MemWrite), 0);
        step("F", 7'b0100011, 1'b0, 1'b0, 1'b0);
        step("F", 7'b0100011, 1'b0, 1'b0, 1'b1);
        run_instr(7'b0010011, 0, 0, 0, 4);

        // Randomized instruction stream with random memory stalls.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: rop = 7'b0000011;
                1: rop = 7'b0100011;
                2: rop = 7'b0110011;
                3: rop = 7'b0010011;
                4: rop = 7'b1100011;
                5: rop = 7'b1101111;
                6: rop = 7'b0110111;
                default: rop = 7'($urandom);
            endcase
            run_instr(rop, 1, 0, 2, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
